regfile_wr_decoder: RTL
=======================

# regfile_wr_decoder

Parametrised, registered write-port decoder for the register file. It converts NPORTS binary write requests into per-register one-hot write enables with a port-select field for each register. It resolves same-register collisions by port priority and keeps a pending-write busy scoreboard for hazard checks. It sits between the writeback stage and the register file's storage array and replaces the fixed 5-to-32 combinational decode used on the single write port.

## Interface
Parameters:
- ADDR_W, 5, register address width; NREGS = 2**ADDR_W (derived, not overridable)
- NPORTS, 2, number of write ports (1..4); SEL_W = max(1, clog2(NPORTS)) (derived)

Ports:
- clock  in  1  sole clock, rising-edge
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset (fixed)
- wr_en  in  NPORTS  per-port write request
- wr_addr  in  NPORTS*ADDR_W  per-port target register; port p occupies bits [p*ADDR_W +: ADDR_W]
- issue_en  in  1  instruction issued with a destination register; marks it busy
- issue_addr  in  ADDR_W  destination register of the issuing instruction
- out_en  out  NREGS  registered one-hot-per-register write enable to storage
- out_sel  out  NREGS*SEL_W  registered winning port index per register; register r occupies bits [r*SEL_W +: SEL_W]
- wr_collide  out  1  registered pulse: two or more enabled ports targeted the same register
- busy  out  NREGS  scoreboard; bit r high while a write to r is pending

## Operation
- Decode: for each enabled port p, register wr_addr[p] is a candidate.
- The highest-index enabled port targeting a register wins (youngest instruction), and its index is written to out_sel for that register.
- Losing ports are dropped silently.
- out_en is the OR over ports of the decoded enables. Multiple bits may be high when ports target different registers.
- out_sel for registers with out_en=0 holds its previous value and is don't-care to consumers.
- wr_collide=1 if any register has two or more enabled candidates after zero-protect filtering. Disabled ports never count.
- Scoreboard update on each edge, per register r:
  - set if issue_en and issue_addr==r
  - else clear if any enabled port targets r
  - else hold
  - Simultaneous issue and write to the same r leaves busy[r]=1 (new pending write).
- No handshake: a write request is always accepted in the cycle it is presented.

## Timing
- Reset values: out_en=0, out_sel=0, wr_collide=0, busy=0.
- Latency: 1 cycle. Requests sampled at edge N appear on out_en/out_sel/wr_collide after edge N and remain valid for exactly one cycle unless re-requested.
- busy changes on the same edge that out_en is registered. A write sampled at edge N clears busy after edge N, not N+1.
- Back-to-back writes to the same register on consecutive cycles produce out_en high for two consecutive cycles.
- Reset asserted mid-operation clears all outputs on that edge. Requests present during reset are discarded, and issue_en during reset does not set busy.
- An out-of-range address cannot occur; every ADDR_W value maps to a register.

## Configuration
- Macro: REGFILE_ZERO_PROTECT_EN.
- Defined:
  - Any write to register 0 is discarded before decode: out_en[0] is always 0, and it is excluded from collision detection.
  - issue_en with issue_addr==0 never sets busy[0]; busy[0] is tied 0.
- Undefined: register 0 is decoded, scoreboarded and collision-checked like every other register.

## Test plan
- Reset, then port0 wr_en=1, wr_addr=5 -> after one edge out_en=0x00000020, out_sel[5]=0, wr_collide=0; the next cycle out_en=0.
- NPORTS=2: port0→7, port1→7 in the same cycle -> out_en=0x80, out_sel[7]=1, wr_collide=1 for one cycle.
- Port0→3, port1→9 in the same cycle -> out_en=0x208, out_sel[3]=0, out_sel[9]=1, wr_collide=0.
- Scoreboard:
  - issue_en with issue_addr=12 -> busy[12]=1.
  - A later write to 12 -> busy[12]=0 after the same edge.
  - issue 12 and write 12 in one cycle -> busy[12] stays 1.
- With REGFILE_ZERO_PROTECT_EN: write to 0 plus issue to 0 -> out_en=0, busy=0, wr_collide=0. Without the macro: out_en[0]=1 and busy[0]=1.
- Writes and issue active, reset pulsed for one cycle -> all outputs 0 after that edge; inputs held during reset have no effect.

Source files
------------

// File: rtl/regfile_wr_decoder.sv
// Registered multi-port write decoder: per-register one-hot enables, port-priority select, busy scoreboard.
// Optional REGFILE_ZERO_PROTECT_EN: register 0 is never written, never collides and never goes busy.
module regfile_wr_decoder #(
  parameter int ADDR_W = 5,
  parameter int NPORTS = 2
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [NPORTS-1:0]                      wr_en,
  input  logic [NPORTS*ADDR_W-1:0]               wr_addr,
  input  logic                                   issue_en,
  input  logic [ADDR_W-1:0]                      issue_addr,
  output logic [(2**ADDR_W)-1:0]                 out_en,
  output logic [(2**ADDR_W)*((NPORTS > 1) ? $clog2(NPORTS) : 1)-1:0] out_sel,
  output logic                                   wr_collide,
  output logic [(2**ADDR_W)-1:0]                 busy
);

  localparam int NREGS = 2**ADDR_W;
  localparam int SEL_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

`ifdef REGFILE_ZERO_PROTECT_EN
  localparam bit ZERO_PROT = 1'b1;
`else
  localparam bit ZERO_PROT = 1'b0;
`endif

  logic [NREGS-1:0]       r_en;
  logic [NREGS*SEL_W-1:0] r_sel;
  logic                   r_collide;
  logic [NREGS-1:0]       r_busy;

  logic [NREGS-1:0]       w_en;
  logic [NREGS*SEL_W-1:0] w_sel;
  logic                   w_collide;
  logic [NREGS-1:0]       w_busy;

  // Ascending port scan: a later (higher-index) hit overwrites the select, so the youngest port wins.
  always_comb begin
    w_en      = '0;
    w_sel     = r_sel;
    w_collide = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      for (int p = 0; p < NPORTS; p++) begin
        if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(r)) && !(ZERO_PROT && (r == 0))) begin
          if (w_en[r]) w_collide = 1'b1;
          w_en[r] = 1'b1;
          w_sel[r*SEL_W +: SEL_W] = SEL_W'(p);
        end
      end
    end
  end

  // A new issue outranks a completing write to the same register.
  always_comb begin
    w_busy = r_busy;
    for (int r = 0; r < NREGS; r++) begin
      if (issue_en && (issue_addr == ADDR_W'(r)) && !(ZERO_PROT && (r == 0)))
        w_busy[r] = 1'b1;
      else if (w_en[r])
        w_busy[r] = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_en      <= '0;
      r_sel     <= '0;
      r_collide <= 1'b0;
      r_busy    <= '0;
    end else begin
      r_en      <= w_en;
      r_sel     <= w_sel;
      r_collide <= w_collide;
      r_busy    <= w_busy;
    end
  end

  assign out_en     = r_en;
  assign out_sel    = r_sel;
  assign wr_collide = r_collide;
  assign busy       = r_busy;

endmodule
